// File: rtl/arr_fill_scheduler.sv
// rtl/arr_fill_scheduler.sv - write arbiter for a register array: single writes vs. whole-array fills
// Round-robin between single-entry writes (W) and multi-cycle fills (F), with a registered write strobe.
module arr_fill_scheduler #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int STEP  = 0,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             fill_valid,
   output logic             fill_ready,
   input  logic [WIDTH-1:0] fill_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata
);

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state, state_nxt;
   logic             rr_fill;            // 1: F wins the next tie
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] step_val;

   assign step_val = WIDTH'(STEP);
   assign rd_data  = mem[rd_addr];

   always_comb begin
      state_nxt  = state;
      wr_ready   = 1'b0;
      fill_ready = 1'b0;
      busy       = 1'b0;
      we         = 1'b0;
      waddr      = idx;
      wdata      = base + WIDTH'(idx) * step_val;
      case (state)
         IDLE: begin
            wr_ready   = wr_valid && (!fill_valid || !rr_fill);
            fill_ready = fill_valid && (!wr_valid || rr_fill);
            if (wr_ready) begin
               we    = 1'b1;
               waddr = wr_addr;
               wdata = wr_data;
            end else if (fill_ready) begin
               we        = 1'b1;
               waddr     = '0;
               wdata     = fill_data;
               state_nxt = FILL;
            end
         end
         FILL: begin
            busy = 1'b1;
            we   = 1'b1;
            if (idx == AW'(DEPTH - 1))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_fill <= 1'b0;
         idx     <= '0;
         base    <= '0;
      end else begin
         state <= state_nxt;
         if (wr_ready)
            rr_fill <= 1'b1;
         else if (fill_ready)
            rr_fill <= 1'b0;
         if (fill_ready) begin
            base <= fill_data;
            idx  <= AW'(1);
         end else if (state == FILL) begin
            idx <= idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Observability copy: one cycle behind the array write it mirrors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= we;
         if (we) begin
            mem_addr  <= waddr;
            mem_wdata <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_arr_fill_scheduler.sv
// tb/tb_arr_fill_scheduler.sv - self-checking bench for arr_fill_scheduler (STEP=0 and STEP=1 instances)
`timescale 1ns/1ps
module tb_arr_fill_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        fill_valid = 1'b0;
   logic [15:0] fill_data = '0;
   logic [1:0]  rd_addr = '0;

   logic        wr_ready0, fill_ready0, busy0, we0;
   logic [1:0]  addr0;
   logic [15:0] wdata0, rd0;
   logic        wr_ready1, fill_ready1, busy1, we1;
   logic [1:0]  addr1;
   logic [15:0] wdata1, rd1;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   always #10 clk = ~clk;

   arr_fill_scheduler #(.DEPTH(4), .WIDTH(16), .STEP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr),
      .wr_data(wr_data), .fill_valid(fill_valid), .fill_ready(fill_ready0), .fill_data(fill_data),
      .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0));

   arr_fill_scheduler #(.DEPTH(4), .WIDTH(16), .STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr),
      .wr_data(wr_data), .fill_valid(fill_valid), .fill_ready(fill_ready1), .fill_data(fill_data),
      .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1));

   // Reference model: array contents, fill progress and arbitration pointer.
   logic [15:0] m0 [4];
   logic [15:0] m1 [4];
   logic        m_busy;
   logic        m_ptr_f;
   int          m_pos;
   logic [15:0] m_base;
   logic        e_we;
   logic [1:0]  e_addr;
   logic [15:0] e_wd0, e_wd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      m_busy = 1'b0; m_ptr_f = 1'b0; m_pos = 0; m_base = '0;
      e_we = 1'b0; e_addr = '0; e_wd0 = '0; e_wd1 = '0;
   endtask

   task automatic check_outputs();
      check("busy0", busy0, m_busy);
      check("busy1", busy1, m_busy);
      check("mem_we0", we0, e_we);
      check("mem_we1", we1, e_we);
      check("mem_addr0", addr0, e_addr);
      check("mem_addr1", addr1, e_addr);
      check("mem_wdata0", wdata0, e_wd0);
      check("mem_wdata1", wdata1, e_wd1);
      if (we0) pulses++;
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         #0.5;
         check($sformatf("rd0[%0d]", a), rd0, m0[a]);
         check($sformatf("rd1[%0d]", a), rd1, m1[a]);
      end
   endtask

   task automatic do_cycle(input logic wv, input logic [1:0] wa, input logic [15:0] wd,
                           input logic fv, input logic [15:0] fd);
      logic ew, ef;
      logic [15:0] v1;
      wr_valid = wv; wr_addr = wa; wr_data = wd; fill_valid = fv; fill_data = fd;
      #1;
      ew = !m_busy && wv && (!fv || !m_ptr_f);
      ef = !m_busy && fv && (!wv || m_ptr_f);
      check("wr_ready0", wr_ready0, ew);
      check("fill_ready0", fill_ready0, ef);
      check("wr_ready1", wr_ready1, ew);
      check("fill_ready1", fill_ready1, ef);
      @(posedge clk);
      e_we = 1'b0;
      if (m_busy) begin
         v1 = m_base + 16'(m_pos);
         m0[m_pos] = m_base;
         m1[m_pos] = v1;
         e_we = 1'b1; e_addr = 2'(m_pos); e_wd0 = m_base; e_wd1 = v1;
         m_pos++;
         if (m_pos == 4) m_busy = 1'b0;
      end else if (ew) begin
         m0[wa] = wd; m1[wa] = wd;
         e_we = 1'b1; e_addr = wa; e_wd0 = wd; e_wd1 = wd;
         m_ptr_f = 1'b1;
      end else if (ef) begin
         m0[0] = fd; m1[0] = fd; m_base = fd;
         e_we = 1'b1; e_addr = '0; e_wd0 = fd; e_wd1 = fd;
         m_pos = 1; m_busy = 1'b1; m_ptr_f = 1'b0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      wr_valid = 1'b0; fill_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_entry(input string tag, input int a, input logic [15:0] v0, input logic [15:0] v1);
      rd_addr = 2'(a);
      #0.2;
      check({tag, "_s0"}, rd0, v0);
      check({tag, "_s1"}, rd1, v1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #3;
      do_reset();

      // Single write to entry 2.
      do_cycle(1'b1, 2'd2, 16'h1234, 1'b0, 16'h0);
      check_entry("wr_e2", 2, 16'h1234, 16'h1234);
      check_entry("wr_e0", 0, 16'h0, 16'h0);

      // Fill with base 3: STEP=0 gives all 3, STEP=1 gives 3..6.
      do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 16'h0003);
      idle_cycles(4);
      check_entry("f3_e3", 3, 16'h0003, 16'h0006);

      // Wrapping fill.
      do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 16'hFFFE);
      idle_cycles(4);
      check_entry("wrap_e1", 1, 16'hFFFE, 16'hFFFF);
      check_entry("wrap_e2", 2, 16'hFFFE, 16'h0000);
      check_entry("wrap_e3", 3, 16'hFFFE, 16'h0001);

      // Both requesters held from reset: W, then F (4 cycles), then W.
      do_reset();
      for (int i = 0; i < 7; i++) do_cycle(1'b1, 2'd3, 16'hA5A5, 1'b1, 16'h0010);
      idle_cycles(4);

      // Reset during the second FILL cycle.
      do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 16'h0777);
      idle_cycles(1);
      #2;
      do_reset();
      check_entry("rst_e0", 0, 16'h0, 16'h0);
      do_cycle(1'b1, 2'd1, 16'hBEEF, 1'b0, 16'h0);
      check_entry("post_rst_e1", 1, 16'hBEEF, 16'hBEEF);

      // Four sequential fills, counting strobe pulses.
      idle_cycles(1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 16'(i + 1));
         idle_cycles(3);
         for (int a = 0; a < 4; a++)
            check_entry("seq_fill", a, 16'(i + 1), 16'(i + 1 + a));
      end
      check("pulse_cnt", pulses, 16);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         do_cycle(1'($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 16'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arr_fill_scheduler.md
Name: arr_fill_scheduler

Overview:
- Owns the DEPTH x WIDTH unpacked register array and arbitrates write access to it between two requesters.
- Requester W issues single-entry writes. Requester F issues whole-array fills, one entry per cycle.
- A combinational read port exposes the contents.
- Sits beside the child2-style storage as its write controller. The write strobe is also exported so waveform tests can trace every array update.

Parameters:
- DEPTH, 4: number of array entries; must be a power of 2, at least 2.
- WIDTH, 16: bits per entry.
- STEP, 0: per-entry increment applied during a fill.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  single-write request.
- wr_ready  out  1  single write accepted this cycle.
- wr_addr  in  $clog2(DEPTH)  target entry.
- wr_data  in  WIDTH  write value.
- fill_valid  in  1  fill request.
- fill_ready  out  1  fill accepted this cycle.
- fill_data  in  WIDTH  fill base value.
- rd_addr  in  $clog2(DEPTH)  read index.
- rd_data  out  WIDTH  array[rd_addr], combinational.
- busy  out  1  fill in progress after the acceptance cycle.
- mem_we  out  1  registered copy of this cycle's array write (observability).
- mem_addr  out  $clog2(DEPTH)  index of that write.
- mem_wdata  out  WIDTH  value of that write.

Behaviour:
- Reset (async assert, sync-released use):
  - all entries = 0; state = IDLE; busy = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - round-robin pointer = W, so W wins the first tie.
  - wr_ready and fill_ready follow their combinational equations.
- FSM states: IDLE, FILL.
- IDLE arbitration (combinational, single cycle):
  - Only wr_valid: wr_ready = 1.
  - Only fill_valid: fill_ready = 1.
  - Both valid: the requester named by the pointer gets ready; the other waits.
  - Neither valid: both readies = 0.
  - A ready is never asserted without its valid.
- Pointer update:
  - On any grant, pointer moves to the non-granted requester.
  - Pointer is unchanged when there is no grant.
- Single write:
  - On the wr_valid && wr_ready edge, array[wr_addr] <= wr_data.
  - Visible on rd_data the next cycle.
  - State stays IDLE.
- Fill acceptance:
  - On the fill_valid && fill_ready edge: base <= fill_data; array[0] <= fill_data; index <= 1; state -> FILL.
- FILL state:
  - Each cycle, array[index] <= base + index*STEP, truncated mod 2^WIDTH; index++.
  - After writing DEPTH-1, state -> IDLE.
  - A fill occupies DEPTH consecutive cycles: 1 acceptance cycle plus DEPTH-1 FILL cycles.
  - Back-to-back grants are allowed on the cycle after returning to IDLE.
- busy:
  - 1 exactly while state == FILL.
  - wr_ready = fill_ready = 0 while busy; requests are held off, not dropped, and inputs are ignored.
- Observability strobe:
  - Every array write in cycle N produces mem_we = 1, mem_addr, mem_wdata in cycle N+1.
  - Otherwise mem_we = 0, and mem_addr/mem_wdata hold their last values.
- Reads:
  - rd_data is pure combinational from the array.
  - A read during a fill shows the partially updated array: entries < index are new, the rest are old.
- Reset mid-fill: fill aborts, all entries return to 0, FSM returns to IDLE; no further writes occur.
- No write collision is possible: at most one array write per cycle by construction.

Test Plan:
- Reset, then wr_valid with addr=2, data=0x1234 → wr_ready = 1 same cycle. Next cycle rd_addr=2 reads 0x1234, mem_we = 1, mem_addr = 2. Other entries read 0.
- fill_valid with data=0x0003, STEP=0 → fill_ready for 1 cycle, busy for 3 cycles. Entries 0..3 = 0x0003. mem_we strobes addr 0,1,2,3 on 4 consecutive cycles.
- STEP=1, fill_data=0xFFFE → entries become 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- wr_valid and fill_valid held high together from reset → grant order W, F (fill runs 4 cycles, wr_ready = 0 throughout), then W. Verifies round-robin and hold-off.
- Assert rst_n low during the 2nd FILL cycle → busy = 0 and all entries 0 immediately (async). Afterwards, a single write to addr 1 succeeds normally.
- Four sequential fills with data i+1 for i = 0..3, reading all entries after each → every entry equals i+1 after fill i; the VCD shows exactly 16 mem_we pulses.
